pipeline_hazard_ctrl: RTL

//  Sequences the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM). It detects

---
 rtl/pipeline_hazard_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, jump/branch squash, dmem freeze, timeout halt.
// Ports: clk/reset, ID/EX/MEM hazard inputs -> stage write-enables, flushes, pc_sel, halted, perf counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_jump,
  input  logic             mem_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_we,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_e;

  localparam logic [7:0]       TMO_LAST = 8'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic frz, lu, sel_br, sel_j, sel_lu;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign frz = mem_access & ~dmem_ready;
  assign lu  = ex_mem_read & (ex_rt != 5'd0) &
               ((ex_rt == id_rs) |
                (id_uses_rt & (ex_rt == id_rt)));

  // One-hot decode selectors: branch beats jump beats load-use.
  assign sel_br = mem_branch_taken;
  assign sel_j  = ex_jump & ~mem_branch_taken;
  assign sel_lu = lu & ~ex_jump & ~mem_branch_taken;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    halted_d    = halted_q;
    stall_d     = stall_q;
    flush_d     = flush_q;
    wait_d      = wait_q;
    pc_we       = 1'b0;
    pc_sel      = 2'b00;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_we     = 1'b0;
    idex_flush  = 1'b0;
    exmem_we    = 1'b0;
    exmem_flush = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_RUN, S_WAIT: begin
          if (frz) begin
            wait_d = sat_inc(wait_q);
            tmo_d  = tmo_q + 8'd1;
            if (tmo_q == TMO_LAST) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            state_d  = S_RUN;
            tmo_d    = 8'd0;
            pc_we    = 1'b1;
            ifid_we  = 1'b1;
            idex_we  = 1'b1;
            exmem_we = 1'b1;
            unique case (1'b1)
              sel_br: begin
                pc_sel      = 2'b01;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                flush_d     = sat_inc(flush_q);
              end
              sel_j: begin
                pc_sel     = 2'b10;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                flush_d    = sat_inc(flush_q);
              end
              // Hold PC and IF/ID; the bubble clears ex_mem_read next cycle.
              sel_lu: begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
                stall_d    = sat_inc(stall_q);
              end
              default: ;
            endcase
          end
        end
        S_HALT: ;
        default: state_d = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_RUN;
      tmo_q    <= 8'd0;
      halted_q <= 1'b0;
      stall_q  <= '0;
      flush_q  <= '0;
      wait_q   <= '0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      halted_q <= halted_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
      wait_q   <= wait_d;
    end
  end

  assign halted    = halted_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign wait_cnt  = wait_q;

endmodule
